// File: rtl/flag_register_stack_if.sv
// Flag register stack bus: ALU/control-side request signals and live flag/stack status.
// The master drives write/push/pop/err_clear; the slave (the register stack) returns state.
interface flag_register_stack_if #(
  parameter int NUM_FLAGS = 4,
  parameter int PTR_W     = 3
);
  logic                 write_enable;
  logic [NUM_FLAGS-1:0] write_mask;
  logic [NUM_FLAGS-1:0] flags_in;
  logic                 push;
  logic                 pop;
  logic                 err_clear;
  logic [NUM_FLAGS-1:0] flags_out;
  logic [PTR_W-1:0]     stack_count;
  logic                 stack_full;
  logic                 stack_empty;
  logic                 stack_error;

  modport master (
    output write_enable, write_mask, flags_in, push, pop, err_clear,
    input  flags_out, stack_count, stack_full, stack_empty, stack_error
  );

  modport slave (
    input  write_enable, write_mask, flags_in, push, pop, err_clear,
    output flags_out, stack_count, stack_full, stack_empty, stack_error
  );
endinterface

// File: rtl/flag_register_stack.sv
// Masked-write condition flag register with a LIFO save/restore stack for interrupt/call entry.
// Latency 1 cycle; no backpressure -- illegal push/pop are dropped and raise a sticky stack_error.
module flag_register_stack #(
  parameter int                   NUM_FLAGS   = 4,
  parameter int                   STACK_DEPTH = 4,
  parameter logic [NUM_FLAGS-1:0] RESET_FLAGS = '0,
  parameter int                   PTR_W       = $clog2(STACK_DEPTH + 1)
) (
  input logic                  clk,
  input logic                  rst,
  flag_register_stack_if.slave bus
);

  logic [NUM_FLAGS-1:0] flags_q;
  logic [PTR_W-1:0]     count_q;
  logic                 err_q;
  logic [NUM_FLAGS-1:0] slots [STACK_DEPTH];
  logic [NUM_FLAGS-1:0] top;
  logic                 full;
  logic                 empty;
  logic                 push_ok;
  logic                 pop_ok;
  logic                 err_ev;

  assign full    = (count_q == PTR_W'(STACK_DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = bus.push & ~bus.pop & ~full;
  assign pop_ok  = bus.pop & ~bus.push & ~empty;
  assign err_ev  = (bus.push & bus.pop) | (bus.push & full) | (bus.pop & empty);

  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (count_q == PTR_W'(i + 1)) top = slots[i];
    end
  end

  // Slots are not reset; only the occupancy count defines which entries are valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (!rst && push_ok && count_q == PTR_W'(i)) slots[i] <= flags_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= RESET_FLAGS;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (pop_ok) begin
        flags_q <= top;
        count_q <= count_q - PTR_W'(1);
      end else begin
        // A push saves the pre-edge flags, so a simultaneous write can clear them.
        if (bus.write_enable)
          flags_q <= (flags_q & ~bus.write_mask) | (bus.flags_in & bus.write_mask);
        if (push_ok) count_q <= count_q + PTR_W'(1);
      end
      if (err_ev)             err_q <= 1'b1;
      else if (bus.err_clear) err_q <= 1'b0;
    end
  end

  assign bus.flags_out   = flags_q;
  assign bus.stack_count = count_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_error = err_q;

endmodule

// File: tb/tb_flag_register_stack.sv
// Scoreboard bench: directed walk through the flag/stack scenarios, then random traffic,
// with expected state from a queue-based reference model compared by a separate monitor.
module tb_flag_register_stack;
  localparam int             NF    = 4;
  localparam int             DEPTH = 4;
  localparam int             PW    = $clog2(DEPTH + 1);
  localparam logic [NF-1:0]  RSTV  = 4'b0000;

  typedef struct {
    logic [NF-1:0] flags;
    int            count;
    logic          full;
    logic          empty;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  exp_t exp_q[$];

  logic [NF-1:0] m_flags;
  logic [NF-1:0] m_stk[$];
  logic          m_err;

  flag_register_stack_if #(.NUM_FLAGS(NF), .PTR_W(PW)) bus ();

  flag_register_stack #(
    .NUM_FLAGS(NF), .STACK_DEPTH(DEPTH), .RESET_FLAGS(RSTV), .PTR_W(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (compared=%0d)", compared);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents state; pop the oldest expectation and compare.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("flags_out",   int'(bus.flags_out),   int'(e.flags));
      chk("stack_count", int'(bus.stack_count), e.count);
      chk("stack_full",  int'(bus.stack_full),  int'(e.full));
      chk("stack_empty", int'(bus.stack_empty), int'(e.empty));
      chk("stack_error", int'(bus.stack_error), int'(e.err));
    end
  end

  // Reference model applies one clock edge's worth of rules to the abstract state.
  task automatic model(input bit r, input bit we, input logic [NF-1:0] m, input logic [NF-1:0] fi,
                       input bit pu, input bit po, input bit ec);
    bit err_now = 0;
    bit do_write = we;
    if (r) begin
      m_flags = RSTV;
      m_stk.delete();
      m_err = 0;
      return;
    end
    if (pu && po) err_now = 1;
    else if (po) begin
      if (m_stk.size() == 0) err_now = 1;
      else begin
        m_flags  = m_stk.pop_back();
        do_write = 0;
      end
    end else if (pu) begin
      if (m_stk.size() == DEPTH) err_now = 1;
      else m_stk.push_back(m_flags);
    end
    if (do_write)
      for (int i = 0; i < NF; i++) if (m[i]) m_flags[i] = fi[i];
    if (err_now) m_err = 1;
    else if (ec) m_err = 0;
  endtask

  task automatic step(input bit r, input bit we, input logic [NF-1:0] m, input logic [NF-1:0] fi,
                      input bit pu, input bit po, input bit ec);
    exp_t e;
    rst = r;
    bus.write_enable = we;
    bus.write_mask   = m;
    bus.flags_in     = fi;
    bus.push         = pu;
    bus.pop          = po;
    bus.err_clear    = ec;
    model(r, we, m, fi, pu, po, ec);
    e.flags = m_flags;
    e.count = m_stk.size();
    e.full  = (m_stk.size() == DEPTH);
    e.empty = (m_stk.size() == 0);
    e.err   = m_err;
    @(posedge clk);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic load(input logic [NF-1:0] v);
    step(0, 1, 4'b1111, v, 0, 0, 0);
  endtask

  initial begin
    m_flags = RSTV;
    m_err   = 0;
    bus.write_enable = 0; bus.write_mask = '0; bus.flags_in = '0;
    bus.push = 0; bus.pop = 0; bus.err_clear = 0;
    @(negedge clk);
    step(1, 0, 4'b0000, 4'b0000, 0, 0, 0);
    step(1, 1, 4'b1111, 4'b1111, 1, 0, 0);

    // Full write, masked write, zero-mask write.
    load(4'b1010);
    step(0, 1, 4'b0001, 4'b0101, 0, 0, 0);
    step(0, 1, 4'b0000, 4'b0101, 0, 0, 0);

    // Push and clear in one cycle, then restore.
    step(0, 1, 4'b1111, 4'b0000, 1, 0, 0);
    step(0, 1, 4'b1111, 4'b1111, 0, 1, 0);

    // Fill, overflow (with a write that still applies), drain in LIFO order.
    for (int i = 0; i < DEPTH; i++) begin
      load(4'(1 << i));
      step(0, 0, 4'b0000, 4'b0000, 1, 0, 0);
    end
    step(0, 1, 4'b0011, 4'b0011, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 4'b0000, 4'b0000, 0, 1, 0);

    // Underflow, clear, push+pop, error beating clear.
    step(0, 0, 4'b0000, 4'b0000, 0, 0, 1);
    load(4'b0110);
    step(0, 0, 4'b0000, 4'b0000, 0, 1, 0);
    step(0, 0, 4'b0000, 4'b0000, 0, 0, 1);
    step(0, 0, 4'b0000, 4'b0000, 1, 0, 0);
    step(0, 1, 4'b1000, 4'b1000, 1, 1, 0);
    step(0, 0, 4'b0000, 4'b0000, 1, 1, 1);
    step(0, 0, 4'b0000, 4'b0000, 0, 0, 1);

    // Reset mid-operation with a pending pop, then a pop on the emptied stack.
    step(0, 0, 4'b0000, 4'b0000, 1, 0, 0);
    step(0, 1, 4'b1111, 4'b1001, 1, 1, 0);
    step(1, 1, 4'b1111, 4'b1111, 0, 1, 0);
    step(0, 0, 4'b0000, 4'b0000, 0, 1, 0);

    for (int n = 0; n < 2000; n++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
           4'($urandom), 4'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/flag_register_stack.md
Name: flag_register_stack

Overview:
- Parametrised successor to the 4-bit CPU flag register.
- Holds NUM_FLAGS condition flags with per-bit write masking.
- Adds a hardware save/restore stack (depth STACK_DEPTH) so the interrupt/call logic can push live flags on entry and pop them on return.
- Sits between the ALU flag outputs and the branch/condition unit; the control FSM drives write, push and pop.

Parameters:
- NUM_FLAGS, 4, number of flag bits. Bit order: 0 = carry, 1 = overflow, 2 = negative, 3 = zero; higher bits are user flags.
- STACK_DEPTH, 4, number of save slots; must be ≥1.
- RESET_FLAGS, 0, value loaded into the live flags on reset.
- PTR_W, $clog2(STACK_DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- write_enable  input  1  update live flags from flags_in where write_mask=1.
- write_mask  input  NUM_FLAGS  per-bit write enable; bits with 0 hold their value.
- flags_in  input  NUM_FLAGS  new flag values from the ALU.
- push  input  1  save the live flags onto the stack.
- pop  input  1  restore the live flags from the top of the stack.
- err_clear  input  1  clear the sticky stack_error.
- flags_out  output  NUM_FLAGS  live flags, registered.
- stack_count  output  PTR_W  number of occupied slots, 0..STACK_DEPTH.
- stack_full  output  1  stack_count == STACK_DEPTH (combinational from count).
- stack_empty  output  1  stack_count == 0 (combinational from count).
- stack_error  output  1  sticky: illegal push, pop, or push+pop.

Behaviour:
- All state changes on the rising edge of clk. No combinational path from inputs to flags_out.

Reset (rst=1 overrides all other inputs):
- flags_out = RESET_FLAGS, stack_count = 0, stack_error = 0.
- Stack contents are don't-care and are not cleared.
- Reset mid-operation discards any push, pop or write in that cycle.

Masked write (no pop this cycle):
- flags_out[i] ← flags_in[i] if write_enable and write_mask[i]; otherwise it holds.
- write_enable=1 with write_mask=0 leaves all flags unchanged.
- Latency: 1 cycle.

Push, legal only when not full:
- slot[stack_count] ← flags_out as it was *before* this edge; stack_count += 1.
- A masked write in the same cycle still updates the live flags. The saved copy is the pre-write value, so interrupt entry can push and clear in one cycle.

Pop, legal only when not empty:
- flags_out ← slot[stack_count-1]; stack_count -= 1.
- Pop has priority over write_enable; a write in the same cycle is ignored entirely.

Illegal cases:
- Push when full: stack unchanged, stack_error ← 1. A write in the same cycle still applies.
- Pop when empty: stack and flags unchanged, stack_error ← 1. A write in the same cycle still applies.
- push and pop together: stack and count unchanged, stack_error ← 1, write_enable still applies.

stack_error:
- Cleared only by rst or by err_clear.
- If err_clear and a new error occur in the same cycle, the error wins (stays 1).

Stack ordering:
- LIFO. No wrap-around; the count saturates at 0 and STACK_DEPTH through the illegal-case rules.
- stack_full and stack_empty follow stack_count in the same cycle.

Test Plan:
1. Reset with RESET_FLAGS=4'b0000, then write_enable=1, mask=4'b1111, flags_in=4'b1010 → next cycle flags_out=4'b1010, stack_empty=1, stack_count=0.
2. Masked write: flags_out=4'b1010, mask=4'b0001, flags_in=4'b0101 → flags_out=4'b1011. Then write_enable=1 with mask=4'b0000 → flags_out stays 4'b1011.
3. Push and clear in one cycle: flags_out=4'b1011, push=1, write mask=4'b1111, flags_in=4'b0000 → flags_out=4'b0000, stack_count=1. Then pop=1 → flags_out=4'b1011, stack_count=0.
4. Fill and overflow: push 4'b0001, 4'b0010, 4'b0100, 4'b1000 (load each first) → stack_full=1, count=4. A 5th push → count stays 4, stack_error=1. Pop ×4 → flags_out 4'b1000, 4'b0100, 4'b0010, 4'b0001 in order, stack_empty=1.
5. Underflow and error clear: pop with empty stack and flags_out=4'b0110 → flags_out stays 4'b0110, stack_error=1. err_clear=1 → stack_error=0. push+pop together → count unchanged, stack_error=1.
6. Reset mid-operation: count=2, assert rst together with pop=1 → next cycle flags_out=RESET_FLAGS, count=0, stack_error=0. Then pop → stack_error=1.
